// File: rtl/bmag_loader.sv
// Host-side bmag grid loader: parses framed UART bytes into BWIDTH-bit words and
// issues one-cycle grid write strobes, validating each frame with an XOR checksum.
module bmag_loader #(
  parameter int         BWIDTH  = 18,
  parameter int         AWIDTH  = 10,
  parameter logic [7:0] HEADER  = 8'hB5,
  parameter int         TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              ui_valid,
  output logic              wen,
  output logic [AWIDTH-1:0] addr_out,
  output logic [BWIDTH-1:0] bmag_out,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int BPW = (BWIDTH + 7) / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, CSUM} state_t;

  state_t            state, state_d;
  logic [7:0]        addr_lo, cnt_lo, csum;
  logic [AWIDTH-1:0] addr;
  logic [15:0]       word_cnt;
  logic [BIW-1:0]    byte_idx;
  logic [7:0]        byte_buf [BPW];
  logic [BPW*8-1:0]  word_asm;
  logic [TW-1:0]     tmo;
  logic              last_byte, timed_out, write_d, done_d, err_d;

  // The final byte of a word goes straight from rx_data into the write, so the
  // word is complete in the same cycle that byte is accepted.
  for (genvar g = 0; g < BPW - 1; g++) begin : g_asm
    assign word_asm[g*8 +: 8] = byte_buf[g];
  end
  assign word_asm[BPW*8-1 -: 8] = rx_data;

  always_comb begin
    state_d   = state;
    write_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    last_byte = (byte_idx == BIW'(BPW - 1));
    timed_out = (state != IDLE) && !rx_valid && (tmo == TW'(TIMEOUT - 1));
    if (timed_out) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        IDLE:  if (rx_data == HEADER) state_d = ADDR0;
        ADDR0: state_d = ADDR1;
        ADDR1: state_d = CNT0;
        CNT0:  state_d = CNT1;
        CNT1:  state_d = ({rx_data, cnt_lo} == 16'd0) ? CSUM : DATA;
        DATA: begin
          if (last_byte) begin
            write_d = 1'b1;
            if (word_cnt == 16'd1) state_d = CSUM;
          end
        end
        CSUM: begin
          state_d = IDLE;
          if (rx_data == csum) done_d = 1'b1;
          else                 err_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ui_valid  <= 1'b0;
      busy      <= 1'b0;
      wen       <= 1'b0;
      addr_out  <= '0;
      bmag_out  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      tmo       <= '0;
      addr_lo   <= '0;
      cnt_lo    <= '0;
      csum      <= '0;
      addr      <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      for (int unsigned i = 0; i < BPW; i++) byte_buf[i] <= '0;
    end else begin
      ui_valid  <= (state_d != IDLE);
      busy      <= (state_d != IDLE);
      wen       <= write_d;
      load_done <= done_d;
      load_err  <= err_d;
      tmo       <= (state_d == IDLE || rx_valid) ? '0 : tmo + 1'b1;
      if (rx_valid) begin
        case (state)
          IDLE: csum <= '0;
          ADDR0: begin
            addr_lo <= rx_data;
            csum    <= csum ^ rx_data;
          end
          ADDR1: begin
            addr <= AWIDTH'({rx_data, addr_lo});
            csum <= csum ^ rx_data;
          end
          CNT0: begin
            cnt_lo <= rx_data;
            csum   <= csum ^ rx_data;
          end
          CNT1: begin
            word_cnt <= {rx_data, cnt_lo};
            byte_idx <= '0;
            csum     <= csum ^ rx_data;
          end
          DATA: begin
            csum <= csum ^ rx_data;
            if (last_byte) begin
              byte_idx <= '0;
              word_cnt <= word_cnt - 16'd1;
              addr     <= addr + 1'b1;
              addr_out <= addr;
              bmag_out <= BWIDTH'(word_asm);
            end else begin
              byte_buf[byte_idx] <= rx_data;
              byte_idx           <= byte_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
